// File: rtl/seg_display_scan_if.sv
// Register-write bus shared by the display scanner and the CPU-side master.
// One write per cycle in which wr_en is high; wr_sel selects the target register.
interface seg_display_scan_if;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;

  modport master (output wr_en, wr_sel, wr_data);
  modport slave  (input  wr_en, wr_sel, wr_data);
endinterface

// File: rtl/seg_display_scan.sv
// Time-multiplexed common-anode 7-segment driver with per-slot blanking and
// frame-synchronous double buffering of the CPU-written digit and dp registers.
module seg_display_scan #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  seg_display_scan_if.slave   bus,
  output logic [DIGITS-1:0]   digit_an,
  output logic [7:0]          seg,
  output logic                frame_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW    = 4 * DIGITS;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(SCAN_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic [DW-1:0]      data_p;
  logic [DW-1:0]      data_a;
  logic [DIGITS-1:0]  dp_p;
  logic [DIGITS-1:0]  dp_a;
  logic               en;

  logic [3:0]         cur_nib;
  logic               cur_dp;

  // Hex to active-low gfedcba.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    unique case (nib)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign cur_nib = 4'(data_a >> {idx, 2'b00});
  assign cur_dp  = dp_a[idx];

  // NOTE: all state and outputs live in one clocked block using <= only, so every
  // read below sees the pre-edge value; this is what lets a frame-end shadow copy
  // take the pending value from before a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      data_p     <= '0;
      data_a     <= '0;
      dp_p       <= '0;
      dp_a       <= '0;
      en         <= 1'b0;
      digit_an   <= '1;
      seg        <= 8'hFF;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (bus.wr_en) begin
        unique case (bus.wr_sel)
          2'd0:    data_p <= bus.wr_data[DW-1:0];
          2'd1:    dp_p   <= bus.wr_data[DIGITS-1:0];
          2'd2:    en     <= bus.wr_data[0];
          default: ;
        endcase
      end

      frame_done <= 1'b0;

      if (!en) begin
        state    <= IDLE;
        cnt      <= '0;
        idx      <= '0;
        digit_an <= '1;
        seg      <= 8'hFF;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= BLANK;
            cnt      <= '0;
            idx      <= '0;
            data_a   <= data_p;
            dp_a     <= dp_p;
            digit_an <= '1;
            seg      <= 8'hFF;
            busy     <= 1'b1;
          end

          BLANK: begin
            cnt <= cnt + 1'b1;
            // Reaching PRE_LAST here only happens when SHOW is a single cycle.
            frame_done <= (cnt == PRE_LAST) && (idx == IDX_LAST);
            if (cnt == BLANK_LAST) begin
              state    <= SHOW;
              digit_an <= ~(DIGITS'(1) << idx);
              seg      <= {~cur_dp, decode(cur_nib)};
            end
          end

          SHOW: begin
            if (cnt == SLOT_LAST) begin
              state    <= BLANK;
              cnt      <= '0;
              digit_an <= '1;
              seg      <= 8'hFF;
              if (idx == IDX_LAST) begin
                idx    <= '0;
                data_a <= data_p;
                dp_a   <= dp_p;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt        <= cnt + 1'b1;
              frame_done <= (cnt == PRE_LAST) && (idx == IDX_LAST);
            end
          end

          default: begin
            state    <= IDLE;
            digit_an <= '1;
            seg      <= 8'hFF;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan: a time-index model of the scan is compared
// against the outputs every cycle, with literal expectations pinning key points.
module tb_seg_display_scan;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic              clk;
  logic              rst;
  logic [DIGITS-1:0] digit_an;
  logic [7:0]        seg;
  logic              frame_done;
  logic              busy;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  seg_display_scan_if bus ();

  seg_display_scan #(
    .DIGITS      (DIGITS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .digit_an  (digit_an),
    .seg       (seg),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment table, gfedcba active-low, indexed by hex digit.
  logic [6:0] hex7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: time since the scan started decides slot/phase; active copy refreshes
  // at start and at every frame boundary from the pending registers.
  logic [31:0] m_data_p, m_data_a;
  logic [7:0]  m_dp_p, m_dp_a;
  bit          m_en, m_run;
  int          m_t;

  always @(posedge clk) begin
    if (rst) begin
      m_data_p = '0; m_data_a = '0; m_dp_p = '0; m_dp_a = '0;
      m_en = 0; m_run = 0; m_t = 0;
    end else begin
      if (!m_en) begin
        m_run = 0;
        m_t   = 0;
      end else if (!m_run) begin
        m_run = 1;
        m_t   = 0;
        m_data_a = m_data_p;
        m_dp_a   = m_dp_p;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_data_a = m_data_p;
          m_dp_a   = m_dp_p;
        end
      end
      if (bus.wr_en) begin
        case (bus.wr_sel)
          2'd0: m_data_p = bus.wr_data;
          2'd1: m_dp_p   = bus.wr_data[7:0];
          2'd2: m_en     = bus.wr_data[0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [DIGITS-1:0] e_an;
      logic [7:0]        e_seg;
      logic              e_fd, e_busy;
      int                phase, slot;
      e_an = '1; e_seg = 8'hFF; e_fd = 1'b0; e_busy = 1'b0;
      if (m_run) begin
        phase  = m_t % SCAN_DIV;
        slot   = (m_t / SCAN_DIV) % DIGITS;
        e_busy = 1'b1;
        e_fd   = (m_t % FRAME) == FRAME - 1;
        if (phase >= BLANK_CYCLES) begin
          e_an  = ~(DIGITS'(1) << slot);
          e_seg = {~m_dp_a[slot], hex7[m_data_a[4*slot +: 4]]};
        end
      end
      check("model_digit_an", 32'(digit_an), 32'(e_an));
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_frame_done", 32'(frame_done), 32'(e_fd));
      check("model_busy", 32'(busy), 32'(e_busy));
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [7:0] sg);
    check({name, "_an"}, 32'(digit_an), 32'(an));
    check({name, "_seg"}, 32'(seg), 32'(sg));
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
    @(posedge clk);
    started = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (100) @(negedge clk);
    lit("reset_idle", 4'hF, 8'hFF);
    check("reset_busy", 32'(busy), 32'd0);

    // Basic scan of 0..3.
    wr(2'd0, 32'h0000_3210);
    wr(2'd2, 32'h1);
    @(negedge clk);
    lit("k0_blank", 4'hF, 8'hFF);
    check("k0_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);  lit("d0", 4'hE, 8'hC0);
    repeat (8) @(negedge clk);  lit("d1", 4'hD, 8'hF9);
    repeat (8) @(negedge clk);  lit("d2", 4'hB, 8'hA4);
    repeat (8) @(negedge clk);  lit("d3", 4'h7, 8'hB0);
    repeat (5) @(negedge clk);  check("fd_pulse", 32'(frame_done), 32'd1);
    @(negedge clk);
    check("fd_clear", 32'(frame_done), 32'd0);
    lit("next_frame_blank", 4'hF, 8'hFF);

    // Decimal points on digits 0 and 2, visible from the following frame.
    wr(2'd1, 32'h05);
    repeat (32) @(negedge clk); lit("dp_d0", 4'hE, 8'h40);
    repeat (8) @(negedge clk);  lit("dp_d1", 4'hD, 8'hF9);
    repeat (8) @(negedge clk);  lit("dp_d2", 4'hB, 8'h24);
    repeat (8) @(negedge clk);  lit("dp_d3", 4'h7, 8'hB0);

    // Mid-frame writes during digit1 must wait for the next frame.
    repeat (15) @(negedge clk);
    wr(2'd0, 32'h0000_FFFF);
    wr(2'd1, 32'h00);
    lit("mid_old_d1", 4'hD, 8'hF9);
    repeat (5) @(negedge clk);  lit("mid_old_d2", 4'hB, 8'h24);
    repeat (16) @(negedge clk); lit("new_d0", 4'hE, 8'h8E);
    repeat (8) @(negedge clk);  lit("new_d1", 4'hD, 8'h8E);

    // Disable during SHOW of digit2, then restart from digit0.
    repeat (7) @(negedge clk);
    wr(2'd2, 32'h0);
    lit("dis_pending", 4'hB, 8'h8E);
    @(negedge clk);
    lit("dis_off", 4'hF, 8'hFF);
    check("dis_busy", 32'(busy), 32'd0);
    wr(2'd2, 32'h1);
    repeat (3) @(negedge clk);  lit("restart_d0", 4'hE, 8'h8E);
    repeat (10) @(negedge clk); lit("pre_rst_d1", 4'hD, 8'h8E);

    // Reset mid-SHOW.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("rst_off", 4'hF, 8'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    repeat (20) @(negedge clk);
    check("rst_stays_idle", 32'(busy), 32'd0);

    // Redundant enable, ignored selector, upper data bits.
    wr(2'd0, 32'hABCD_5678);
    wr(2'd2, 32'h1);
    repeat (20) @(negedge clk);
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hDEAD_BEEF);
    repeat (70) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
